// File: rtl/pulse_interval_meter.sv
// Measures clk cycles between two consecutive rising edges of pulse_in, with saturation and timeout.
// Define PULSE_INTERVAL_SYNC_EN to pass pulse_in through a two-flop synchronizer first.
module pulse_interval_meter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             arm,
    input  logic [CNT_W-1:0] timeout,
    input  logic             ack,
    output logic [CNT_W-1:0] interval,
    output logic             valid,
    output logic             busy,
    output logic             timed_out,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        MEASURE    = 2'd2,
        DONE       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    state_t           state_q, state_d;
    logic             p_s, p_d_q, rise;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] tcnt_q, tcnt_d, tcnt_inc;
    logic [CNT_W-1:0] to_q, to_d;
    logic [CNT_W-1:0] int_q, int_d;
    logic             tof_q, tof_d;
    logic             ovf_q, ovf_d;
    logic             tmo_hit;

`ifdef PULSE_INTERVAL_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pulse_in;
            sync2_q <= sync1_q;
        end
    end

    assign p_s = sync2_q;
`else
    assign p_s = pulse_in;
`endif

    assign rise     = p_s & ~p_d_q;
    assign cnt_inc  = sat_inc(cnt_q);
    assign tcnt_inc = tcnt_q + CNT_ONE;
    // Compare against the post-increment value so valid lands T+1 cycles after arm.
    assign tmo_hit  = (to_q != '0) && (tcnt_inc == to_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        to_d    = to_q;
        int_d   = int_q;
        tof_d   = tof_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = WAIT_FIRST;
                    to_d    = timeout;
                    tcnt_d  = '0;
                    tof_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            WAIT_FIRST: begin
                tcnt_d = tcnt_inc;
                if (tmo_hit) begin
                    int_d   = '0;
                    tof_d   = 1'b1;
                    state_d = DONE;
                end else if (rise) begin
                    cnt_d   = '0;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                tcnt_d = tcnt_inc;
                // A closing edge beats a coincident timeout.
                if (rise) begin
                    int_d   = cnt_inc;
                    state_d = DONE;
                end else if (tmo_hit) begin
                    int_d   = cnt_inc;
                    tof_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) ovf_d = 1'b1;
                end
            end
            DONE: begin
                if (ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            p_d_q   <= 1'b0;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            to_q    <= '0;
            int_q   <= '0;
            tof_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_d_q   <= p_s;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            to_q    <= to_d;
            int_q   <= int_d;
            tof_q   <= tof_d;
            ovf_q   <= ovf_d;
        end
    end

    assign interval  = int_q;
    assign valid     = (state_q == DONE);
    assign busy      = (state_q == WAIT_FIRST) || (state_q == MEASURE);
    assign timed_out = tof_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_pulse_interval_meter.sv
// Bench for pulse_interval_meter: table-driven cases scored on valid, plus reset and saturation sequences.
module tb_pulse_interval_meter;

`ifdef PULSE_INTERVAL_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk, rst;
    logic        pulse_in, arm, ack;
    logic [31:0] timeout, interval;
    logic        valid, busy, timed_out, overflow;

    logic        pulse4, arm4, ack4;
    logic [3:0]  timeout4, interval4;
    logic        valid4, busy4, timed_out4, overflow4;

    pulse_interval_meter #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .arm(arm), .timeout(timeout), .ack(ack),
        .interval(interval), .valid(valid), .busy(busy), .timed_out(timed_out), .overflow(overflow)
    );

    pulse_interval_meter #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .pulse_in(pulse4), .arm(arm4), .timeout(timeout4), .ack(ack4),
        .interval(interval4), .valid(valid4), .busy(busy4), .timed_out(timed_out4), .overflow(overflow4)
    );

    typedef struct {
        logic [31:0] to;
        int          d1;
        int          n;
        int          hold;
        int          arm2;
        bit          ackarm;
        logic [31:0] e_int;
        bit          e_to;
        bit          e_ov;
        int          vcyc;
    } vec_t;

    typedef struct {
        logic [31:0] i;
        bit          to;
        bit          ov;
        int          cyc;
    } exp_t;

    vec_t tbl[9];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   vrise_cnt = 0;
    logic vprev = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0b expected %0b", nm, act, exp);
        end
    endtask

    // Scoreboard: every rising valid consumes one expected result.
    always @(negedge clk) begin
        if (valid && !vprev) begin
            vrise_cnt <= vrise_cnt + 1;
            chk1("valid_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                chk32("sb_interval", interval, sb[0].i);
                chk1("sb_timed_out", timed_out, sb[0].to);
                chk1("sb_overflow", overflow, sb[0].ov);
                chk32("sb_valid_cycle", cyc, sb[0].cyc);
                sb.delete(0);
            end
        end
        vprev <= valid;
    end

    task automatic run_case(input int idx, input vec_t v);
        int   c0, base, last;
        bit   hi;
        exp_t e;
        base = vrise_cnt;
        last = (v.d1 == 0) ? 0 : ((v.n != 0) ? v.d1 + v.n : v.d1 + v.hold);
        if (v.arm2 > last) last = v.arm2;
        timeout = v.to;
        c0 = cyc;
        e.i = v.e_int; e.to = v.e_to; e.ov = v.e_ov; e.cyc = c0 + v.vcyc;
        sb.push_back(e);
        for (int k = 0; k < 300; k++) begin
            if (vrise_cnt != base && k > last) break;
            hi = (v.d1 != 0) && ((k >= v.d1 && k < v.d1 + v.hold) || (v.n != 0 && k == v.d1 + v.n));
            pulse_in = hi;
            arm = (k == 0) || (v.arm2 != 0 && k == v.arm2);
            @(posedge clk); #1;
        end
        pulse_in = 1'b0;
        arm = 1'b0;
        if (vrise_cnt == base) begin
            chk1("valid_timeout", 1'b0, 1'b1);
            $display("  case %0d", idx);
            sb.delete();
        end
        @(negedge clk);
        chk1("hold_valid", valid, 1'b1);
        chk32("hold_interval", interval, v.e_int);
        @(posedge clk); #1;
        ack = 1'b1;
        arm = v.ackarm;
        @(negedge clk);
        chk1("valid_in_ack_cycle", valid, 1'b1);
        @(posedge clk); #1;
        ack = 1'b0;
        arm = 1'b0;
        @(negedge clk);
        chk1("valid_after_ack", valid, 1'b0);
        chk1("busy_after_ack", busy, 1'b0);
        if (v.ackarm) begin
            repeat (3) begin
                @(negedge clk);
                chk1("ackarm_busy", busy, 1'b0);
                chk1("ackarm_valid", valid, 1'b0);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic run4(input int n, input logic [3:0] e_int, input logic e_ov);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            arm4 = (k == 0);
            pulse4 = (k == 2) || (k == 2 + n);
            @(negedge clk);
            if (valid4) seen = 1'b1;
            @(posedge clk); #1;
        end
        arm4 = 1'b0;
        pulse4 = 1'b0;
        chk1("w4_valid_seen", seen, 1'b1);
        chk32("w4_interval", {28'd0, interval4}, {28'd0, e_int});
        chk1("w4_overflow", overflow4, e_ov);
        chk1("w4_timed_out", timed_out4, 1'b0);
        ack4 = 1'b1;
        @(posedge clk); #1;
        ack4 = 1'b0;
        @(negedge clk);
        chk1("w4_valid_after_ack", valid4, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pulse_in = 1'b0; arm = 1'b0; ack = 1'b0; timeout = 32'd0;
        pulse4 = 1'b0; arm4 = 1'b0; ack4 = 1'b0; timeout4 = 4'd0;

        tbl[0] = '{to:32'd0,       d1:3,       n:7,  hold:1,  arm2:0,  ackarm:1'b0, e_int:32'd7,  e_to:1'b0, e_ov:1'b0, vcyc:11+LAT};
        tbl[1] = '{to:32'd0,       d1:2,       n:2,  hold:1,  arm2:0,  ackarm:1'b0, e_int:32'd2,  e_to:1'b0, e_ov:1'b0, vcyc:5+LAT};
        tbl[2] = '{to:32'd20,      d1:0,       n:0,  hold:0,  arm2:0,  ackarm:1'b0, e_int:32'd0,  e_to:1'b1, e_ov:1'b0, vcyc:21};
        tbl[3] = '{to:32'd20,      d1:5-LAT,   n:0,  hold:1,  arm2:0,  ackarm:1'b0, e_int:32'd15, e_to:1'b1, e_ov:1'b0, vcyc:21};
        tbl[4] = '{to:32'd0,       d1:4,       n:30, hold:10, arm2:15, ackarm:1'b0, e_int:32'd30, e_to:1'b0, e_ov:1'b0, vcyc:35+LAT};
        tbl[5] = '{to:32'(10+LAT), d1:3,       n:7,  hold:1,  arm2:0,  ackarm:1'b0, e_int:32'd7,  e_to:1'b0, e_ov:1'b0, vcyc:11+LAT};
        tbl[6] = '{to:32'd8,       d1:3-LAT,   n:7,  hold:1,  arm2:0,  ackarm:1'b0, e_int:32'd5,  e_to:1'b1, e_ov:1'b0, vcyc:9};
        tbl[7] = '{to:32'd1,       d1:0,       n:0,  hold:0,  arm2:0,  ackarm:1'b0, e_int:32'd0,  e_to:1'b1, e_ov:1'b0, vcyc:2};
        tbl[8] = '{to:32'd0,       d1:2,       n:4,  hold:1,  arm2:0,  ackarm:1'b1, e_int:32'd4,  e_to:1'b0, e_ov:1'b0, vcyc:7+LAT};

        repeat (2) @(posedge clk);
        #1;
        chk32("rst_interval", interval, 32'd0);
        chk1("rst_valid", valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_timed_out", timed_out, 1'b0);
        chk1("rst_overflow", overflow, 1'b0);
        rst = 1'b0;

        // Pulse activity without arm must not start anything.
        for (int k = 0; k < 10; k++) begin
            pulse_in = (k % 2 == 1);
            @(negedge clk);
            chk1("idle_valid", valid, 1'b0);
            chk1("idle_busy", busy, 1'b0);
            @(posedge clk); #1;
        end
        pulse_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) run_case(i, tbl[i]);

        // Reset in the middle of a measurement.
        timeout = 32'd0;
        arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
        for (int k = 1; k < 9; k++) begin
            pulse_in = (k == 2);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk1("mid_busy", busy, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk32("mid_rst_interval", interval, 32'd0);
        chk1("mid_rst_valid", valid, 1'b0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_timed_out", timed_out, 1'b0);
        chk1("mid_rst_overflow", overflow, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        pulse_in = 1'b0;
        @(negedge clk);
        chk1("post_rst_busy", busy, 1'b0);
        chk1("post_rst_valid", valid, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        run_case(100, tbl[0]);

        run4(20, 4'd15, 1'b1);
        run4(5, 4'd5, 1'b0);

        chk32("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
